// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Purpose  : Shares one 8-digit seven-segment display between N_REQ
//            requesters. Fixed priority (index 0 highest), a minimum
//            ownership hold before a higher-priority requester may preempt,
//            a forced blanking gap before every new grant, and an optional
//            per-requester blink of the display enable.
// Ports    : clk          system clock
//            rst          asynchronous reset, active low
//            req[N]       level request per requester, held while displaying
//            blink[N]     flash the display while that requester owns it
//            signs_in     requester i codes at [32*i+31:32*i], nibble k=digit k
//            grant[N]     one-hot current owner, zero when nobody owns it
//            disp_en      display enable to the digit-multiplexing driver
//            sign7..sign0 digit codes to the driver, sign0 = rightmost digit
// Revision : 1.0  initial release
// ============================================================================
module seg_display_arbiter #(
  parameter int N_REQ        = 3,
  parameter int HOLD_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_HALF   = 12500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     blink,
  input  logic [32*N_REQ-1:0]  signs_in,
  output logic [N_REQ-1:0]     grant,
  output logic                 disp_en,
  output logic [3:0]           sign7,
  output logic [3:0]           sign6,
  output logic [3:0]           sign5,
  output logic [3:0]           sign4,
  output logic [3:0]           sign3,
  output logic [3:0]           sign2,
  output logic [3:0]           sign1,
  output logic [3:0]           sign0
);

  localparam int c_idx_w   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_hold_w  = $clog2(HOLD_CYCLES + 1);
  localparam int c_blank_w = $clog2(BLANK_CYCLES + 1);
  localparam int c_blink_w = $clog2(BLINK_HALF + 1);

  localparam logic [c_hold_w-1:0]  c_hold_max  = c_hold_w'(HOLD_CYCLES);
  localparam logic [c_blank_w-1:0] c_blank_ld  = c_blank_w'(BLANK_CYCLES - 1);
  localparam logic [c_blink_w-1:0] c_blink_end = c_blink_w'(BLINK_HALF - 1);
  localparam logic [N_REQ-1:0]     c_one       = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_OWN   = 2'd2
  } state_t;

  // Arbitration state
  state_t               r_state;
  logic [c_idx_w-1:0]   r_pending;
  logic [c_idx_w-1:0]   r_owner;
  logic [c_blank_w-1:0] r_blank_cnt;
  logic [c_hold_w-1:0]  r_hold_cnt;

  // Output stage
  logic [N_REQ-1:0]     r_grant;
  logic                 r_disp_en;
  logic [31:0]          r_signs;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_phase;

  // Next-state values
  state_t               w_next_state;
  logic [c_idx_w-1:0]   w_next_pending;
  logic [c_idx_w-1:0]   w_next_owner;
  logic [c_blank_w-1:0] w_next_blank_cnt;
  logic [c_hold_w-1:0]  w_next_hold_cnt;

  logic [c_idx_w-1:0]   w_win;
  logic                 w_any_req;
  logic [N_REQ-1:0]     w_owner_onehot;
  logic                 w_higher_req;
  logic                 w_owner_req;
  logic                 w_pending_req;
  logic                 w_owner_blink;
  logic [31:0]          w_owner_signs;

  // Lowest-index active request wins.
  always_comb begin
    w_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win = c_idx_w'(i);
      end
    end
  end

  // Code word of the current owner.
  always_comb begin
    w_owner_signs = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == c_idx_w'(i)) begin
        w_owner_signs = signs_in[32*i +: 32];
      end
    end
  end

  assign w_any_req      = |req;
  assign w_owner_onehot = c_one << r_owner;
  // Mask of all indices strictly below the owner (higher priority).
  assign w_higher_req   = |(req & (w_owner_onehot - c_one));
  assign w_owner_req    = req[r_owner];
  assign w_pending_req  = req[r_pending];
  assign w_owner_blink  = blink[r_owner];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_owner     <= '0;
      r_blank_cnt <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_pending   <= w_next_pending;
      r_owner     <= w_next_owner;
      r_blank_cnt <= w_next_blank_cnt;
      r_hold_cnt  <= w_next_hold_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state     = r_state;
    w_next_pending   = r_pending;
    w_next_owner     = r_owner;
    w_next_blank_cnt = r_blank_cnt;
    w_next_hold_cnt  = r_hold_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next_state     = ST_BLANK;
          w_next_pending   = w_win;
          w_next_blank_cnt = c_blank_ld;
        end
      end

      ST_BLANK: begin
        // Pending follows the current winner without restarting the gap.
        if (w_any_req) begin
          w_next_pending = w_win;
        end
        if (r_blank_cnt == '0) begin
          if (w_pending_req) begin
            w_next_state    = ST_OWN;
            w_next_owner    = r_pending;
            w_next_hold_cnt = '0;
          end else if (!w_any_req) begin
            w_next_state = ST_IDLE;
          end else begin
            // Pending dropped at the last moment: start a fresh gap.
            w_next_blank_cnt = c_blank_ld;
          end
        end else begin
          w_next_blank_cnt = r_blank_cnt - 1'b1;
        end
      end

      ST_OWN: begin
        if (r_hold_cnt != c_hold_max) begin
          w_next_hold_cnt = r_hold_cnt + 1'b1;
        end
        // Release takes precedence over preemption; both lead to BLANK.
        if (!w_owner_req) begin
          if (w_any_req) begin
            w_next_state     = ST_BLANK;
            w_next_pending   = w_win;
            w_next_blank_cnt = c_blank_ld;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else if (w_higher_req && (r_hold_cnt == c_hold_max)) begin
          w_next_state     = ST_BLANK;
          w_next_pending   = w_win;
          w_next_blank_cnt = c_blank_ld;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output stage. Grant is asserted only while ownership continues, so it
  // drops on the same edge the FSM leaves OWN. Signs and enable follow the
  // registered grant one cycle later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant       <= '0;
      r_disp_en     <= 1'b0;
      r_signs       <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else begin
      if ((r_state == ST_OWN) && (w_next_state == ST_OWN)) begin
        r_grant <= w_owner_onehot;
      end else begin
        r_grant <= '0;
      end

      if (r_grant != '0) begin
        r_signs <= w_owner_signs;
        if (w_owner_blink) begin
          r_disp_en <= r_blink_phase;
          if (r_blink_cnt == c_blink_end) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end else begin
          r_disp_en     <= 1'b1;
          r_blink_cnt   <= '0;
          r_blink_phase <= 1'b1;
        end
      end else begin
        // Not displaying: blink restarts "on" at the next ownership.
        r_signs       <= '0;
        r_disp_en     <= 1'b0;
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b1;
      end
    end
  end

  assign grant   = r_grant;
  assign disp_en = r_disp_en;
  assign sign7   = r_signs[31:28];
  assign sign6   = r_signs[27:24];
  assign sign5   = r_signs[23:20];
  assign sign4   = r_signs[19:16];
  assign sign3   = r_signs[15:12];
  assign sign2   = r_signs[11:8];
  assign sign1   = r_signs[7:4];
  assign sign0   = r_signs[3:0];

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_arbiter
// Purpose  : Directed self-checking bench for seg_display_arbiter with
//            N_REQ=3, HOLD_CYCLES=8, BLANK_CYCLES=2, BLINK_HALF=3.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_display_arbiter;

  localparam logic [31:0] c_slot0 = 32'h9ABCDEF0;
  localparam logic [31:0] c_slot1 = 32'h12345678;
  localparam logic [31:0] c_slot2 = 32'h0F1E2D3C;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  blink;
  logic [95:0] signs_in;
  logic [2:0]  grant;
  logic        disp_en;
  logic [3:0]  sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0;
  logic [31:0] signs_obs;

  int errors = 0;
  int checks = 0;

  seg_display_arbiter #(
    .N_REQ        (3),
    .HOLD_CYCLES  (8),
    .BLANK_CYCLES (2),
    .BLINK_HALF   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .blink    (blink),
    .signs_in (signs_in),
    .grant    (grant),
    .disp_en  (disp_en),
    .sign7    (sign7),
    .sign6    (sign6),
    .sign5    (sign5),
    .sign4    (sign4),
    .sign3    (sign3),
    .sign2    (sign2),
    .sign1    (sign1),
    .sign0    (sign0)
  );

  assign signs_obs = {sign7, sign6, sign5, sign4, sign3, sign2, sign1, sign0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] blink_pat;
    rst      = 1'b0;
    req      = 3'b000;
    blink    = 3'b000;
    signs_in = {c_slot2, c_slot1, c_slot0};

    // Reset values
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_disp", 32'(disp_en), 32'h0);
    chk("rst_signs", signs_obs, 32'h0);
    rst = 1'b1;
    repeat (4) tick();
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_disp", 32'(disp_en), 32'h0);
    chk("idle_signs", signs_obs, 32'h0);

    // First grant to requester 1, latency through the blanking gap
    req = 3'b010;
    tick();  // edge n
    chk("t1_disp_n1", 32'(disp_en), 32'h0);
    tick();  // n+1
    chk("t1_disp_n2", 32'(disp_en), 32'h0);
    tick();  // n+2
    chk("t1_grant_n2", 32'(grant), 32'h0);
    tick();  // n+3
    chk("t1_grant_n3", 32'(grant), 32'h2);
    chk("t1_disp_n3", 32'(disp_en), 32'h0);
    tick();  // n+4
    chk("t1_signs_n4", signs_obs, c_slot1);
    chk("t1_disp_n4", 32'(disp_en), 32'h1);

    // Release with no other request
    req = 3'b000;
    tick();
    chk("rel_grant", 32'(grant), 32'h0);
    chk("rel_disp_lag", 32'(disp_en), 32'h1);
    tick();
    chk("rel_disp", 32'(disp_en), 32'h0);
    chk("rel_signs", signs_obs, 32'h0);
    repeat (2) tick();

    // Owner 2, then req[0] arrives while hold_cnt=3
    req = 3'b100;
    repeat (6) tick();  // edges a..a+5
    chk("t2_grant_own2", 32'(grant), 32'h4);
    chk("t2_signs_own2", signs_obs, c_slot2);
    req = 3'b101;
    for (int i = 0; i < 5; i++) begin
      tick();  // a+6..a+10: hold not yet satisfied
      chk("t2_hold_keep", 32'(grant), 32'h4);
    end
    tick();  // a+11: preempt
    chk("t2_preempt_drop", 32'(grant), 32'h0);
    repeat (2) tick();  // a+13
    chk("t2_blank_gap", 32'(grant), 32'h0);
    tick();  // a+14
    chk("t2_grant_own0", 32'(grant), 32'h1);
    tick();
    chk("t2_signs_own0", signs_obs, c_slot0);
    chk("t2_disp_own0", 32'(disp_en), 32'h1);

    // Lower-priority request never preempts
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t3_no_lower_preempt", 32'(grant), 32'h1);
    end
    req = 3'b100;
    tick();  // b
    chk("t3_release", 32'(grant), 32'h0);
    tick();  // b+1
    chk("t3_blank_disp", 32'(disp_en), 32'h0);
    tick();  // b+2
    chk("t3_blank_grant", 32'(grant), 32'h0);
    tick();  // b+3
    chk("t3_grant_own2", 32'(grant), 32'h4);

    // Blink while owner 1
    req   = 3'b010;
    blink = 3'b010;
    tick();  // c
    chk("t4_release", 32'(grant), 32'h0);
    repeat (3) tick();  // c+3
    chk("t4_grant_own1", 32'(grant), 32'h2);
    chk("t4_disp_pre", 32'(disp_en), 32'h0);
    blink_pat = 5'b00111;  // bit k = expected disp_en after edge c+4+k
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_blink_pat", 32'(disp_en), 32'(blink_pat[k]));
    end
    blink = 3'b000;
    tick();
    chk("t4_blink_clear", 32'(disp_en), 32'h1);
    tick();
    chk("t4_blink_steady", 32'(disp_en), 32'h1);

    // Pending retargets during BLANK without extra blanking
    req = 3'b000;
    repeat (3) tick();
    req = 3'b110;
    tick();  // d: pending = 1
    chk("t5_blank_start", 32'(grant), 32'h0);
    req = 3'b100;
    tick();  // d+1: pending -> 2
    tick();  // d+2
    chk("t5_blank_end", 32'(grant), 32'h0);
    tick();  // d+3
    chk("t5_grant_own2", 32'(grant), 32'h4);
    tick();  // d+4
    chk("t5_signs_own2", signs_obs, c_slot2);
    chk("t5_disp_own2", 32'(disp_en), 32'h1);

    // Asynchronous reset while owning
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_disp", 32'(disp_en), 32'h0);
    chk("t6_rst_signs", signs_obs, 32'h0);
    req = 3'b000;
    #3;
    rst = 1'b1;
    repeat (3) tick();
    chk("t6_post_grant", 32'(grant), 32'h0);
    chk("t6_post_disp", 32'(disp_en), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
